// File: rtl/coeff_pkg.sv
// rtl/coeff_pkg.sv - shared constants, header layout and FSM states for the coefficient bank loader
package coeff_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_SEG    = 4;
  localparam int SEG_LEN    = 10;
  localparam int BANK_DEPTH = NUM_SEG * SEG_LEN;
  localparam int ADDR_W     = $clog2(BANK_DEPTH);

  localparam logic [7:0] HDR_SYNC = 8'hC0;

  localparam int HDR_SYNC_LSB  = 24;
  localparam int HDR_SEG_LSB   = 16;
  localparam int HDR_CNT_LSB   = 8;
  localparam int HDR_START_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    DRAIN,
    COMMIT
  } state_t;

  typedef struct packed {
    logic [7:0] sync;
    logic [1:0] seg;
    logic [3:0] cnt_m1;
    logic [3:0] start;
  } coeff_hdr_t;

  // First bank address of a segment; constant multiply, only used at header time.
  function automatic logic [ADDR_W-1:0] seg_base(input logic [1:0] seg);
    return ADDR_W'(int'(seg) * SEG_LEN);
  endfunction

endpackage

// File: rtl/coeff_hdr_decode.sv
// rtl/coeff_hdr_decode.sv - combinational frame header unpack and validity check
module coeff_hdr_decode
  import coeff_pkg::*;
(
  input  logic [DATA_W-1:0] hdr,
  output logic [1:0]        seg,
  output logic [3:0]        start,
  output logic [3:0]        cnt_m1,
  output logic              ok
);

  coeff_hdr_t h;
  logic       unused_bits;

  always_comb begin
    h.sync   = hdr[HDR_SYNC_LSB  +: 8];
    h.seg    = hdr[HDR_SEG_LSB   +: 2];
    h.cnt_m1 = hdr[HDR_CNT_LSB   +: 4];
    h.start  = hdr[HDR_START_LSB +: 4];
  end

  assign unused_bits = ^{hdr[23:18], hdr[15:12], hdr[7:4]};

  assign seg    = h.seg;
  assign start  = h.start;
  assign cnt_m1 = h.cnt_m1;

  // The frame must lie entirely inside one segment.
  assign ok = (h.sync == HDR_SYNC)
           && (int'(h.seg) < NUM_SEG)
           && (int'(h.start) < SEG_LEN)
           && (int'(h.cnt_m1) < SEG_LEN)
           && (int'(h.start) + int'(h.cnt_m1) + 1 <= SEG_LEN);

endmodule

// File: rtl/coeff_bank_loader.sv
// rtl/coeff_bank_loader.sv - stream-to-bank coefficient frame writer; COEFF_SHADOW_EN selects shadow-bank commit
module coeff_bank_loader
  import coeff_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [DATA_W-1:0] config_reg [BANK_DEPTH-1:0],
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        k_q;
  logic [3:0]        cnt_m1_q;
  logic [1:0]        seg_q;

  logic [1:0]        hdr_seg;
  logic [3:0]        hdr_start;
  logic [3:0]        hdr_cnt_m1;
  logic              hdr_ok;

  logic              hdr_take;
  logic              wr_en;
  logic              commit;
  logic              reload;

  coeff_hdr_decode u_hdr_decode (
    .hdr    (s_data),
    .seg    (hdr_seg),
    .start  (hdr_start),
    .cnt_m1 (hdr_cnt_m1),
    .ok     (hdr_ok)
  );

  assign wr_addr = base_q + ADDR_W'(k_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // s_ready depends on state only, so s_valid is used directly for the accept terms.
  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b1;
    busy      = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    hdr_take  = 1'b0;
    wr_en     = 1'b0;
    commit    = 1'b0;
    reload    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (s_valid) begin
          if (s_last) begin
            load_err = 1'b1;
          end else if (hdr_ok) begin
            hdr_take = 1'b1;
            state_d  = DATA;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DATA: begin
        if (s_valid) begin
          wr_en = 1'b1;
          if (k_q == cnt_m1_q) begin
            state_d = s_last ? COMMIT : DRAIN;
          end else if (s_last) begin
            load_err = 1'b1;
            reload   = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      DRAIN: begin
        if (s_valid && s_last) begin
          load_err = 1'b1;
          reload   = 1'b1;
          state_d  = IDLE;
        end
      end
      COMMIT: begin
        s_ready   = 1'b0;
        load_done = 1'b1;
        commit    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      k_q      <= '0;
      cnt_m1_q <= '0;
      seg_q    <= '0;
    end else if (hdr_take) begin
      base_q   <= seg_base(hdr_seg) + ADDR_W'(hdr_start);
      k_q      <= '0;
      cnt_m1_q <= hdr_cnt_m1;
      seg_q    <= hdr_seg;
    end else if (wr_en) begin
      k_q <= k_q + 4'd1;
    end
  end

`ifdef COEFF_SHADOW_EN
  logic [DATA_W-1:0] shadow [BANK_DEPTH-1:0];

  // Shadow mirrors config_reg outside a frame; an error restores the frame's segment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BANK_DEPTH; i++) begin
        shadow[i]     <= '0;
        config_reg[i] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SEG; s++) begin
        for (int j = 0; j < SEG_LEN; j++) begin
          if (reload && int'(seg_q) == s)
            shadow[s*SEG_LEN+j] <= config_reg[s*SEG_LEN+j];
          else if (wr_en && wr_addr == ADDR_W'(s*SEG_LEN+j))
            shadow[s*SEG_LEN+j] <= s_data;
          if (commit && int'(seg_q) == s)
            config_reg[s*SEG_LEN+j] <= shadow[s*SEG_LEN+j];
        end
      end
    end
  end
`else
  logic unused_ctl;

  assign unused_ctl = ^{reload, commit, seg_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BANK_DEPTH; i++) config_reg[i] <= '0;
    end else if (wr_en) begin
      config_reg[wr_addr] <= s_data;
    end
  end
`endif

endmodule

// File: tb/tb_coeff_bank_loader.sv
// tb/tb_coeff_bank_loader.sv - table-driven, scoreboarded bench for coeff_bank_loader
module tb_coeff_bank_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [31:0] config_reg [39:0];
  logic        busy;
  logic        load_done;
  logic        load_err;

  coeff_bank_loader dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .config_reg (config_reg),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hdr;
    int          n;
    logic [31:0] d0;
    logic [31:0] step;
    logic        exp_done;
    string       name;
  } vec_t;

  typedef struct {
    logic done;
    int   cyc;
  } ev_t;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          last_cyc;
  int          hdr_cyc;
  logic [31:0] exp_bank [40];
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  vec_t        vecs [13];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (load_done) obs_q.push_back('{done: 1'b1, cyc: cyc});
      if (load_err)  obs_q.push_back('{done: 1'b0, cyc: cyc});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic l, output int acc);
    int   tries = 0;
    logic rdy = 1'b0;
    acc = cyc;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!rdy && tries < 20) begin
      @(negedge clk);
      rdy = s_ready;
      acc = cyc;
      tick();
      tries++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL put_timeout: s_ready stayed %b, required 1", rdy);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  function automatic void model_frame(input vec_t v);
    int seg, cm1, st, cnt, nw;
    bit ok;
    seg = int'(v.hdr[17:16]);
    cm1 = int'(v.hdr[11:8]);
    st  = int'(v.hdr[3:0]);
    ok  = (v.hdr[31:24] == 8'hC0) && seg < 4 && st < 10 && cm1 < 10 && st + cm1 + 1 <= 10;
    cnt = cm1 + 1;
    if (!ok || v.n == 0) return;
    nw = (v.n < cnt) ? v.n : cnt;
`ifdef COEFF_SHADOW_EN
    if (v.n != cnt) nw = 0;
`endif
    for (int k = 0; k < nw; k++) exp_bank[seg*10 + st + k] = v.d0 + k * v.step;
  endfunction

  task automatic check_bank(input string name);
    int bad = -1;
    checks++;
    for (int i = 0; i < 40; i++)
      if (config_reg[i] !== exp_bank[i] && bad < 0) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s bank[%0d]: got %h, required %h", name, bad, config_reg[bad], exp_bank[bad]);
    end
  endtask

  task automatic check_events(input string name);
    ev_t e, o;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s event: got none, required done=%b at cycle %0d", name, e.done, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.done !== e.done || o.cyc != e.cyc) begin
          errors++;
          $display("FAIL %s event: got done=%b at cycle %0d, required done=%b at cycle %0d",
                   name, o.done, o.cyc, e.done, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s extra_events: got %0d, required 0", name, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  task automatic run_frame(input vec_t v, input int gap, input bit settle);
    int          c;
    logic [31:0] d;
    put(v.hdr, v.n == 0, c);
    hdr_cyc = c;
    check_bit({v.name, " busy_after_hdr"}, busy, v.n != 0);
    d = v.d0;
    for (int k = 0; k < v.n; k++) begin
      repeat (gap) tick();
      put(d, k == v.n - 1, c);
      d = d + v.step;
    end
    last_cyc = c;
    exp_q.push_back('{done: v.exp_done, cyc: v.exp_done ? c + 1 : c});
    model_frame(v);
    if (settle) begin
      repeat (3) tick();
      check_events(v.name);
      check_bank(v.name);
      check_bit({v.name, " busy_idle"}, busy, 1'b0);
    end
  endtask

  initial begin
    int   c;
    int   b2b_first;
    vec_t va, vb;

    vecs[0]  = '{32'hC000_0900, 10, 32'h1,      32'h1,    1'b1, "full_seg0"};
    vecs[1]  = '{32'hC003_0108, 2,  32'hAAAA,   32'h1111, 1'b1, "seg3_tail"};
    vecs[2]  = '{32'hA500_0200, 3,  32'hDEAD,   32'h1,    1'b0, "bad_sync"};
    vecs[3]  = '{32'hC001_0302, 2,  32'h4400,   32'h1,    1'b0, "short"};
    vecs[4]  = '{32'hC002_0208, 3,  32'h5500,   32'h1,    1'b0, "overflow"};
    vecs[5]  = '{32'hC002_0100, 4,  32'h6600,   32'h1,    1'b0, "long"};
    vecs[6]  = '{32'hC001_0000, 0,  32'h0,      32'h0,    1'b0, "empty"};
    vecs[7]  = '{32'hC003_0900, 10, 32'h7700,   32'h3,    1'b1, "full_seg3"};
    vecs[8]  = '{32'hC001_0009, 1,  32'h8800,   32'h0,    1'b1, "start9_cnt1"};
    vecs[9]  = '{32'hC000_0A00, 1,  32'h9900,   32'h0,    1'b0, "cnt11"};
    vecs[10] = '{32'hC000_000A, 1,  32'hAA00,   32'h0,    1'b0, "start10"};
    vecs[11] = '{32'hC000_0203, 3,  32'h5000,   32'h10,   1'b1, "seg0_mid"};
    vecs[12] = '{32'hA500_0000, 0,  32'h0,      32'h0,    1'b0, "bad_empty"};

    for (int i = 0; i < 40; i++) exp_bank[i] = '0;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    check_bit("reset s_ready", s_ready, 1'b1);
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset load_done", load_done, 1'b0);
    check_bit("reset load_err", load_err, 1'b0);
    check_bank("reset");

    for (int i = 0; i < 13; i++) run_frame(vecs[i], 0, 1'b1);

    // Back-to-back: second header must be taken the cycle after COMMIT.
    va = '{32'hC001_0104, 2, 32'h100, 32'h1, 1'b1, "b2b_a"};
    vb = '{32'hC001_0106, 2, 32'h200, 32'h1, 1'b1, "b2b_b"};
    run_frame(va, 0, 1'b0);
    b2b_first = last_cyc;
    run_frame(vb, 0, 1'b1);
    checks++;
    if (hdr_cyc != b2b_first + 2) begin
      errors++;
      $display("FAIL b2b_hdr_cycle: got %0d, required %0d", hdr_cyc, b2b_first + 2);
    end

    run_frame('{32'hC002_0405, 5, 32'h300, 32'h1, 1'b1, "stalled"}, 2, 1'b1);
    run_frame('{32'hC000_0301, 6, 32'h400, 32'h1, 1'b0, "long_stalled"}, 1, 1'b1);

    // Reset in the middle of a DATA phase.
    put(32'hC000_0900, 1'b0, c);
    for (int k = 0; k < 5; k++) put(32'hF0 + k, 1'b0, c);
    rst = 1'b1;
    #2;
    for (int i = 0; i < 40; i++) exp_bank[i] = '0;
    check_bank("midreset");
    check_bit("midreset busy", busy, 1'b0);
    check_bit("midreset s_ready", s_ready, 1'b1);
    #1;
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    tick();
    run_frame(vecs[0], 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
